// File: rtl/processor_pkg.sv
// Shared encodings for the processor sequencer: opcodes, ALU functions and FSM states.
// Opcodes are plain integers so they can be compared against any OPC_W opcode field.
package processor_pkg;

    localparam int unsigned OP_NOP   = 32'h0;
    localparam int unsigned OP_LOAD  = 32'h1;
    localparam int unsigned OP_STORE = 32'h2;
    localparam int unsigned OP_ADD   = 32'h3;
    localparam int unsigned OP_SUB   = 32'h4;
    localparam int unsigned OP_AND   = 32'h5;
    localparam int unsigned OP_OR    = 32'h6;
    localparam int unsigned OP_XOR   = 32'h7;
    localparam int unsigned OP_LDI   = 32'h8;
    localparam int unsigned OP_JMP   = 32'h9;
    localparam int unsigned OP_JZ    = 32'hA;
    localparam int unsigned OP_JNZ   = 32'hB;
    localparam int unsigned OP_HALT  = 32'hF;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_XOR    = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StOpFetch = 3'd2,
        StOpLatch = 3'd3,
        StExecute = 3'd4,
        StHalt    = 3'd5
    } state_e;

    // Instructions that carry an operand word after the opcode word.
    function automatic logic is_two_word(input int unsigned op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JNZ);
    endfunction

endpackage

// File: rtl/processor_decode.sv
// Combinational strobe decoder: maps FSM state and the latched instruction word onto
// datapath enables, ALU function, halted and the illegal-instruction flag.
module processor_decode
    import processor_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OPC_W    = 4,
    parameter int unsigned NUM_REGS = 2
) (
    input  logic [2:0]        i_state,
    input  logic [DATA_W-1:0] i_ir,
    output logic              o_reg_ce,
    output logic              o_reg_oe,
    output logic              o_load_en,
    output logic              o_store_en,
    output logic              o_acu_we,
    output logic [2:0]        o_alu_op,
    output logic              o_imm_oe,
    output logic              o_illegal,
    output logic              o_halted
);

    localparam int unsigned OPR_W = DATA_W - OPC_W;

    logic [OPC_W-1:0] w_opcode;
    logic [OPR_W-1:0] w_operand;
    int unsigned      w_op;
    logic             w_reg_ok;
    logic             w_exec;
    alu_op_e          w_alu;

    assign w_opcode  = i_ir[DATA_W-1 -: OPC_W];
    assign w_operand = i_ir[OPR_W-1:0];
    assign w_op      = 32'(w_opcode);
    assign w_reg_ok  = 32'(w_operand) < NUM_REGS;
    assign w_exec    = (i_state == StExecute);
    assign o_alu_op  = w_alu;

    always_comb begin
        o_reg_ce   = 1'b0;
        o_reg_oe   = 1'b0;
        o_load_en  = 1'b0;
        o_store_en = 1'b0;
        o_acu_we   = 1'b0;
        o_imm_oe   = 1'b0;
        o_illegal  = 1'b0;
        o_halted   = (i_state == StHalt);
        w_alu      = ALU_PASS_B;

        if (w_exec) begin
            case (w_op)
                OP_NOP, OP_JMP, OP_JZ, OP_JNZ: begin
                end
                OP_LOAD: begin
                    if (w_reg_ok) begin
                        o_reg_oe  = 1'b1;
                        o_load_en = 1'b1;
                        o_acu_we  = 1'b1;
                    end else begin
                        o_illegal = 1'b1;
                    end
                end
                OP_STORE: begin
                    if (w_reg_ok) begin
                        o_reg_ce   = 1'b1;
                        o_store_en = 1'b1;
                    end else begin
                        o_illegal = 1'b1;
                    end
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    if (w_reg_ok) begin
                        o_reg_oe = 1'b1;
                        o_acu_we = 1'b1;
                        case (w_op)
                            OP_ADD:  w_alu = ALU_ADD;
                            OP_SUB:  w_alu = ALU_SUB;
                            OP_AND:  w_alu = ALU_AND;
                            OP_OR:   w_alu = ALU_OR;
                            default: w_alu = ALU_XOR;
                        endcase
                    end else begin
                        o_illegal = 1'b1;
                    end
                end
                OP_LDI: begin
                    o_imm_oe = 1'b1;
                    o_acu_we = 1'b1;
                end
                // HALT reports halted already in its EXECUTE cycle, then stays in StHalt.
                OP_HALT: o_halted = 1'b1;
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/processor_ctrl.sv
// Fetch/decode/execute sequencer: owns the FSM and the pc, instruction and operand
// registers; datapath enables come from processor_decode.
module processor_ctrl
    import processor_pkg::*;
#(
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned PC_W      = 5,
    parameter  int unsigned OPC_W     = 4,
    parameter  int unsigned NUM_REGS  = 2,
    localparam int unsigned REG_SEL_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 run,
    input  logic [DATA_W-1:0]    prog_data,
    input  logic                 acu_zero,
    output logic [PC_W-1:0]      prog_addr,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 reg_ce,
    output logic                 reg_oe,
    output logic                 load_en,
    output logic                 store_en,
    output logic                 acu_we,
    output logic [2:0]           alu_op,
    output logic                 imm_oe,
    output logic [DATA_W-1:0]    imm_data,
    output logic [OPC_W-1:0]     instr_code,
    output logic                 halted,
    output logic                 illegal_instr
);

    state_e            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_opr;

    int unsigned       w_op;
    int unsigned       w_next_op;
    logic [PC_W-1:0]   w_jump_tgt;
    logic              w_take_jump;

    assign w_op       = 32'(r_ir[DATA_W-1 -: OPC_W]);
    assign w_next_op  = 32'(prog_data[DATA_W-1 -: OPC_W]);
    // Truncates when PC_W < DATA_W, zero-extends when PC_W > DATA_W.
    assign w_jump_tgt = PC_W'(r_opr);

    always_comb begin
        w_take_jump = 1'b0;
        case (w_op)
            OP_JMP:  w_take_jump = 1'b1;
            OP_JZ:   w_take_jump = acu_zero;
            OP_JNZ:  w_take_jump = ~acu_zero;
            default: w_take_jump = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StFetch;
            r_pc    <= '0;
            r_ir    <= '0;
            r_opr   <= '0;
        end else begin
            case (r_state)
                StFetch: begin
                    if (run) r_state <= StDecode;
                end
                StDecode: begin
                    r_ir    <= prog_data;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= is_two_word(w_next_op) ? StOpFetch : StExecute;
                end
                StOpFetch: begin
                    r_state <= StOpLatch;
                end
                StOpLatch: begin
                    r_opr   <= prog_data;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= StExecute;
                end
                StExecute: begin
                    if (w_take_jump) r_pc <= w_jump_tgt;
                    r_state <= (w_op == OP_HALT) ? StHalt : StFetch;
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: r_state <= StFetch;
            endcase
        end
    end

    assign prog_addr  = r_pc;
    assign reg_sel    = r_ir[REG_SEL_W-1:0];
    assign imm_data   = r_opr;
    assign instr_code = r_ir[DATA_W-1 -: OPC_W];

    processor_decode #(
        .DATA_W   (DATA_W),
        .OPC_W    (OPC_W),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .i_state    (r_state),
        .i_ir       (r_ir),
        .o_reg_ce   (reg_ce),
        .o_reg_oe   (reg_oe),
        .o_load_en  (load_en),
        .o_store_en (store_en),
        .o_acu_we   (acu_we),
        .o_alu_op   (alu_op),
        .o_imm_oe   (imm_oe),
        .o_illegal  (illegal_instr),
        .o_halted   (halted)
    );

endmodule

// File: tb/tb_processor_ctrl.sv
// Directed bench for processor_ctrl: an instruction-level model pushes the expected
// per-cycle outputs to a scoreboard that is popped and compared every clock.
module tb_processor_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       run = 1'b0;
    logic       acu_zero = 1'b0;
    logic [7:0] prog_data = 8'h00;

    logic [4:0] prog_addr;
    logic [0:0] reg_sel;
    logic       reg_ce, reg_oe, load_en, store_en, acu_we, imm_oe, halted, illegal_instr;
    logic [2:0] alu_op;
    logic [7:0] imm_data;
    logic [3:0] instr_code;

    typedef struct packed {
        logic [4:0] addr;
        logic       rsel;
        logic       ce;
        logic       oe;
        logic       ld;
        logic       st;
        logic       we;
        logic [2:0] alu;
        logic       imm_oe;
        logic [7:0] imm;
        logic [3:0] code;
        logic       hlt;
        logic       ill;
    } obs_t;

    obs_t       exp_q[$];
    logic [7:0] mem [32];
    logic [4:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_opr;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    processor_ctrl #(
        .DATA_W   (8),
        .PC_W     (5),
        .OPC_W    (4),
        .NUM_REGS (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .run           (run),
        .prog_data     (prog_data),
        .acu_zero      (acu_zero),
        .prog_addr     (prog_addr),
        .reg_sel       (reg_sel),
        .reg_ce        (reg_ce),
        .reg_oe        (reg_oe),
        .load_en       (load_en),
        .store_en      (store_en),
        .acu_we        (acu_we),
        .alu_op        (alu_op),
        .imm_oe        (imm_oe),
        .imm_data      (imm_data),
        .instr_code    (instr_code),
        .halted        (halted),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data valid one cycle after the address.
    always @(posedge clk) prog_data <= mem[prog_addr];

    function automatic obs_t base_obs(input logic [4:0] addr);
        obs_t o;
        o      = '0;
        o.addr = addr;
        o.rsel = m_ir[0];
        o.code = m_ir[7:4];
        o.imm  = m_opr;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.addr   = prog_addr;
        o.rsel   = reg_sel[0];
        o.ce     = reg_ce;
        o.oe     = reg_oe;
        o.ld     = load_en;
        o.st     = store_en;
        o.we     = acu_we;
        o.alu    = alu_op;
        o.imm_oe = imm_oe;
        o.imm    = imm_data;
        o.code   = instr_code;
        o.hlt    = halted;
        o.ill    = illegal_instr;
        return o;
    endfunction

    task automatic model_reset();
        m_pc  = 5'd0;
        m_ir  = 8'h00;
        m_opr = 8'h00;
        exp_q.delete();
    endtask

    // Expected outputs for one instruction starting in FETCH with run already high.
    task automatic model_instr();
        obs_t       e;
        logic [7:0] w0;
        logic [3:0] op;
        logic [3:0] rn;
        logic [4:0] nxt;
        w0 = mem[m_pc];
        exp_q.push_back(base_obs(m_pc));
        exp_q.push_back(base_obs(m_pc));
        m_ir = w0;
        m_pc = m_pc + 5'd1;
        op   = w0[7:4];
        rn   = w0[3:0];
        if (op >= 4'h8 && op <= 4'hB) begin
            exp_q.push_back(base_obs(m_pc));
            exp_q.push_back(base_obs(m_pc));
            m_opr = mem[m_pc];
            m_pc  = m_pc + 5'd1;
        end
        e   = base_obs(m_pc);
        nxt = m_pc;
        case (op)
            4'h1: if (rn < 4'd2) begin e.oe = 1'b1; e.ld = 1'b1; e.we = 1'b1; end
                  else e.ill = 1'b1;
            4'h2: if (rn < 4'd2) begin e.ce = 1'b1; e.st = 1'b1; end
                  else e.ill = 1'b1;
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                if (rn < 4'd2) begin
                    e.oe  = 1'b1;
                    e.we  = 1'b1;
                    e.alu = 3'(op - 4'd2);
                end else begin
                    e.ill = 1'b1;
                end
            end
            4'h8: begin e.imm_oe = 1'b1; e.we = 1'b1; end
            4'h9: nxt = m_opr[4:0];
            4'hA: if (acu_zero) nxt = m_opr[4:0];
            4'hB: if (!acu_zero) nxt = m_opr[4:0];
            4'hC, 4'hD, 4'hE: e.ill = 1'b1;
            4'hF: e.hlt = 1'b1;
            default: ;
        endcase
        exp_q.push_back(e);
        m_pc = nxt;
    endtask

    task automatic model_hold(input int n);
        repeat (n) exp_q.push_back(base_obs(m_pc));
    endtask

    task automatic model_halt(input int n);
        obs_t o;
        o     = base_obs(m_pc);
        o.hlt = 1'b1;
        repeat (n) exp_q.push_back(o);
    endtask

    // Called right after a falling edge; samples mid-cycle, then waits for the next one.
    task automatic check_cycle(input string tag);
        obs_t got;
        obs_t exp;
        #1;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard empty at cyc=%0d", tag, cyc);
            $fatal(1, "scoreboard underflow");
        end
        exp = exp_q.pop_front();
        got = dut_obs();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h (addr %h/%h)",
                   tag, cyc, got, exp, got.addr, exp.addr);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_n(input string tag, input int n);
        repeat (n) check_cycle(tag);
    endtask

    task automatic check_all(input string tag);
        while (exp_q.size() > 0) check_cycle(tag);
    endtask

    task automatic check_reset(input string tag);
        obs_t got;
        #1;
        got = dut_obs();
        checks++;
        assert (got === obs_t'('0)) else begin
            failures++;
            $error("FAIL %s observed=%h expected=0", tag, got);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic restart();
        rstn = 1'b0;
        check_reset("reset_outputs");
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        clear_mem();
        mem[0] = 8'h90;
        mem[1] = 8'h07;
        run    = 1'b1;
        #1 rstn = 1'b0;
        check_reset("power_on_reset");
        @(negedge clk);
        @(negedge clk);

        // JMP: run up to OPLATCH, then reset mid-instruction.
        model_reset();
        rstn = 1'b1;
        model_instr();
        check_n("jmp_before_reset", 3);
        rstn = 1'b0;
        check_reset("reset_mid_oplatch");
        @(negedge clk);
        @(negedge clk);

        // LDI 0x05; STORE R1; ADD R1; HALT
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h05; mem[2] = 8'h21; mem[3] = 8'h31; mem[4] = 8'hF0;
        model_reset();
        rstn = 1'b1;
        repeat (4) model_instr();
        model_halt(4);
        check_all("prog_ldi_store_add_halt");

        // Taken JZ, untaken JNZ, illegal operand and opcode, legal ALU ops.
        restart();
        clear_mem();
        mem[5'h00] = 8'hA0; mem[5'h01] = 8'h10;
        mem[5'h10] = 8'hB0; mem[5'h11] = 8'h14;
        mem[5'h12] = 8'h13; mem[5'h13] = 8'hD0; mem[5'h14] = 8'h11;
        mem[5'h15] = 8'h50; mem[5'h16] = 8'h70; mem[5'h17] = 8'hF0;
        acu_zero = 1'b1;
        model_reset();
        rstn = 1'b1;
        repeat (8) model_instr();
        model_halt(2);
        check_all("prog_jumps_illegal");

        // JMP whose operand wraps to address 0, untaken JZ, HALT.
        restart();
        clear_mem();
        mem[5'h00] = 8'h03; mem[5'h01] = 8'h90; mem[5'h02] = 8'h1F;
        mem[5'h1F] = 8'h90; mem[5'h03] = 8'hA0; mem[5'h04] = 8'h10; mem[5'h05] = 8'hF0;
        acu_zero = 1'b0;
        model_reset();
        rstn = 1'b1;
        repeat (5) model_instr();
        model_halt(2);
        check_all("prog_pc_wrap");

        // run gating: hold in FETCH, then a one-cycle pulse runs exactly one instruction.
        restart();
        clear_mem();
        mem[0] = 8'h61; mem[1] = 8'hF0;
        run = 1'b0;
        model_reset();
        rstn = 1'b1;
        model_hold(4);
        check_all("run_low_hold");
        run = 1'b1;
        model_instr();
        check_cycle("run_pulse_fetch");
        run = 1'b0;
        check_all("run_pulse_exec");
        model_hold(3);
        check_all("run_low_after_pulse");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
